pulse_timestamp_fifo: RTL and testbench

//  Consumes the single-cycle pulse stream from the random pulse generator and stamps each pulse

---
 rtl/pulse_gen_pkg.sv | 7 +
 rtl/pulse_timestamp_fifo_if.sv | 29 ++
 rtl/ts_sync_fifo.sv | 64 ++++++
 rtl/pulse_timestamp_fifo.sv | 70 +++++++
 tb/tb_pulse_timestamp_fifo.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pulse_gen_pkg.sv
// Shared defaults for the pulse generator / timestamp FIFO slice.
// No ports; constants only.
package pulse_gen_pkg;
  localparam int TS_WIDTH_DEF   = 16;
  localparam int DEPTH_LN2_DEF  = 3;
  localparam int DROP_WIDTH_DEF = 8;
endpackage

// File: rtl/pulse_timestamp_fifo_if.sv
// Bus between pulse source / stamp consumer and the timestamp FIFO.
// master: drives ce, clear, pulse_in, ts_ready; slave: drives stamps and status.
interface pulse_timestamp_fifo_if
  import pulse_gen_pkg::*;
#(
  parameter int TS_WIDTH   = TS_WIDTH_DEF,
  parameter int DEPTH_LN2  = DEPTH_LN2_DEF,
  parameter int DROP_WIDTH = DROP_WIDTH_DEF
);
  logic                  ce;
  logic                  clear;
  logic                  pulse_in;
  logic [TS_WIDTH-1:0]   ts_data;
  logic                  ts_valid;
  logic                  ts_ready;
  logic [DEPTH_LN2:0]    fifo_level;
  logic                  overflow;
  logic [DROP_WIDTH-1:0] drop_count;

  modport master (
    output ce, clear, pulse_in, ts_ready,
    input  ts_data, ts_valid, fifo_level, overflow, drop_count
  );

  modport slave (
    input  ce, clear, pulse_in, ts_ready,
    output ts_data, ts_valid, fifo_level, overflow, drop_count
  );
endinterface

// File: rtl/ts_sync_fifo.sv
// First-word-fall-through FIFO with registered head, MSB-compare pointers.
// Ports: clk, rst_n, push, pop, flush, din -> dout, full, empty, level.
module ts_sync_fifo #(
  parameter int WIDTH     = 16,
  parameter int DEPTH_LN2 = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push,
  input  logic                 pop,
  input  logic                 flush,
  input  logic [WIDTH-1:0]     din,
  output logic [WIDTH-1:0]     dout,
  output logic                 full,
  output logic                 empty,
  output logic [DEPTH_LN2:0]   level
);
  localparam int DEPTH = 1 << DEPTH_LN2;
  localparam logic [DEPTH_LN2:0] ONE = 1;

  logic [WIDTH-1:0]     mem [DEPTH];
  logic [DEPTH_LN2:0]   wr_ptr;
  logic [DEPTH_LN2:0]   rd_ptr;
  logic [DEPTH_LN2-1:0] wr_idx;
  logic [DEPTH_LN2-1:0] rd_nxt;

  assign wr_idx = wr_ptr[DEPTH_LN2-1:0];
  assign rd_nxt = rd_ptr[DEPTH_LN2-1:0] + ONE[DEPTH_LN2-1:0];
  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[DEPTH_LN2] != rd_ptr[DEPTH_LN2]) &&
                  (wr_idx == rd_ptr[DEPTH_LN2-1:0]);
  assign level  = wr_ptr - rd_ptr;

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_idx] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ONE;
      if (pop)  rd_ptr <= rd_ptr + ONE;
    end
  end

  // Head register: keeps its last value once the FIFO runs dry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout <= '0;
    end else if (!flush) begin
      if (pop) begin
        if (level > ONE) dout <= mem[rd_nxt];
        else if (push)   dout <= din;
      end else if (empty && push) begin
        dout <= din;
      end
    end
  end
endmodule

// File: rtl/pulse_timestamp_fifo.sv
// Stamps generator pulses with a free-running ce-cycle count and buffers them.
// Ports: clk, rst_n, bus (slave): ce, clear, pulse_in, ts_* handshake, status.
module pulse_timestamp_fifo
  import pulse_gen_pkg::*;
#(
  parameter int TS_WIDTH   = TS_WIDTH_DEF,
  parameter int DEPTH_LN2  = DEPTH_LN2_DEF,
  parameter int DROP_WIDTH = DROP_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pulse_timestamp_fifo_if.slave bus
);
  localparam logic [TS_WIDTH-1:0]   TS_ONE   = 1;
  localparam logic [DROP_WIDTH-1:0] DROP_ONE = 1;

  logic [TS_WIDTH-1:0]   ts;
  logic                  push_req;
  logic                  pop;
  logic                  push;
  logic                  drop;
  logic                  full;
  logic                  empty;
  logic                  ovf;
  logic [DROP_WIDTH-1:0] drops;

  assign push_req = bus.pulse_in & bus.ce & ~bus.clear;
  assign pop      = ~empty & bus.ts_ready & ~bus.clear;
  // A pop in the same cycle frees the slot a full FIFO needs.
  assign push     = push_req & (~full | pop);
  assign drop     = push_req & full & ~pop;

  assign bus.ts_valid   = ~empty;
  assign bus.overflow   = ovf;
  assign bus.drop_count = drops;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      ts <= '0;
    else if (bus.ce) ts <= ts + TS_ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf   <= 1'b0;
      drops <= '0;
    end else if (bus.clear) begin
      ovf   <= 1'b0;
      drops <= '0;
    end else if (drop) begin
      ovf <= 1'b1;
      if (drops != '1) drops <= drops + DROP_ONE;
    end
  end

  ts_sync_fifo #(
    .WIDTH     (TS_WIDTH),
    .DEPTH_LN2 (DEPTH_LN2)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (bus.clear),
    .din   (ts),
    .dout  (bus.ts_data),
    .full  (full),
    .empty (empty),
    .level (bus.fifo_level)
  );
endmodule

// File: tb/tb_pulse_timestamp_fifo.sv
// Randomised and directed bench for pulse_timestamp_fifo (16-bit and 4-bit stamps).
// Reference model: a queue of stamps plus a ce counter.
module tb_pulse_timestamp_fifo;
  import pulse_gen_pkg::*;
  localparam int D = 1 << DEPTH_LN2_DEF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  pulse_timestamp_fifo_if #(.TS_WIDTH(16), .DEPTH_LN2(3), .DROP_WIDTH(8)) b();
  pulse_timestamp_fifo_if #(.TS_WIDTH(4), .DEPTH_LN2(3), .DROP_WIDTH(8)) b4();

  assign b4.ce       = b.ce;
  assign b4.clear    = b.clear;
  assign b4.pulse_in = b.pulse_in;
  assign b4.ts_ready = b.ts_ready;

  pulse_timestamp_fifo #(.TS_WIDTH(16), .DEPTH_LN2(3), .DROP_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .bus(b.slave));
  pulse_timestamp_fifo #(.TS_WIDTH(4), .DEPTH_LN2(3), .DROP_WIDTH(8)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(b4.slave));

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] m_ts;
  logic [15:0] m_head;
  logic [15:0] q[$];
  bit          m_ovf;
  int          m_drops;

  task automatic model_reset();
    q.delete();
    m_ts = '0; m_head = '0; m_ovf = 0; m_drops = 0;
  endtask

  task automatic set_in(bit ce, bit pulse, bit ready, bit clr);
    b.ce = ce; b.pulse_in = pulse; b.ts_ready = ready; b.clear = clr;
  endtask

  // One clock: model decides from pre-edge inputs, commits after the edge.
  task automatic step();
    bit pop, push, full, ce_s, clr;
    ce_s = b.ce;
    clr  = b.clear;
    pop  = (q.size() > 0) && b.ts_ready && !clr;
    push = b.pulse_in && ce_s && !clr;
    full = (q.size() == D);
    @(posedge clk); #1;
    if (clr) begin
      q.delete(); m_ovf = 0; m_drops = 0;
    end else begin
      if (pop) void'(q.pop_front());
      if (push) begin
        if (!full || pop) q.push_back(m_ts);
        else begin
          m_ovf = 1;
          if (m_drops < 255) m_drops++;
        end
      end
    end
    if (q.size() > 0) m_head = q[0];
    if (ce_s) m_ts++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_in(0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_in(1, 1, 1, 0);
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (b.ts_valid !== 1'b0) begin
      miscompares++; $display("FAIL reset_valid got %0b want 0", b.ts_valid);
    end
    vectors++;
    if (b.ts_data !== 16'd0 || b.fifo_level !== 4'd0) begin
      miscompares++;
      $display("FAIL reset_data_level got %0d/%0d want 0/0", b.ts_data, b.fifo_level);
    end
    vectors++;
    if (b.overflow !== 1'b0 || b.drop_count !== 8'd0) begin
      miscompares++;
      $display("FAIL reset_status got %0b/%0d want 0/0", b.overflow, b.drop_count);
    end
    do_reset();
  endtask

  task automatic test_basic();
    logic [15:0] st;
    bit pp;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      st = m_ts;
      pp = (st == 16'd5) || (st == 16'd9);
      set_in(1, pp, 1, 0);
      step();
      vectors++;
      if (b.ts_valid !== pp) begin
        miscompares++; $display("FAIL basic_valid cyc %0d got %0b want %0b", i, b.ts_valid, pp);
      end
      if (pp) begin
        vectors++;
        if (b.ts_data !== st || b4.ts_data !== st[3:0]) begin
          miscompares++;
          $display("FAIL basic_data got %0d/%0d want %0d", b.ts_data, b4.ts_data, st);
        end
      end
    end
  endtask

  task automatic test_overflow();
    logic [15:0] exp_seq[9];
    for (int i = 0; i < 8; i++) exp_seq[i] = 16'(i);
    exp_seq[8] = 16'd10;
    do_reset();
    set_in(1, 1, 0, 0);
    repeat (10) step();
    vectors++;
    if (b.fifo_level !== 4'd8 || b.overflow !== 1'b1 || b.drop_count !== 8'd2) begin
      miscompares++;
      $display("FAIL ovf_status got lvl %0d ovf %0b drops %0d want 8/1/2",
               b.fifo_level, b.overflow, b.drop_count);
    end
    for (int k = 0; k < 9; k++) begin
      vectors++;
      if (b.ts_valid !== 1'b1 || b.ts_data !== exp_seq[k] || b.ts_data !== m_head) begin
        miscompares++;
        $display("FAIL drain_data k %0d got %0d want %0d", k, b.ts_data, exp_seq[k]);
      end
      set_in(1, k == 0, 1, 0);
      step();
      if (k == 0) begin
        vectors++;
        if (b.fifo_level !== 4'd8 || b.drop_count !== 8'd2) begin
          miscompares++;
          $display("FAIL full_pushpop got lvl %0d drops %0d want 8/2", b.fifo_level, b.drop_count);
        end
      end
    end
    vectors++;
    if (b.ts_valid !== 1'b0 || b.fifo_level !== 4'd0 || b.ts_data !== 16'd10) begin
      miscompares++;
      $display("FAIL drain_end got v %0b lvl %0d data %0d want 0/0/10",
               b.ts_valid, b.fifo_level, b.ts_data);
    end
  endtask

  task automatic test_wrap();
    logic [15:0] st;
    bit pp;
    int seen = 0;
    logic [3:0] want [2];
    want[0] = 4'd14; want[1] = 4'd2;
    do_reset();
    for (int i = 0; i < 21; i++) begin
      st = m_ts;
      pp = (st == 16'd14) || (st == 16'd18);
      set_in(1, pp, 1, 0);
      step();
      if (pp) begin
        vectors++;
        if (b4.ts_valid !== 1'b1 || b4.ts_data !== want[seen]) begin
          miscompares++;
          $display("FAIL wrap_data got %0d want %0d", b4.ts_data, want[seen]);
        end
        seen++;
      end
    end
    vectors++;
    if (b4.overflow !== 1'b0 || b4.drop_count !== 8'd0) begin
      miscompares++; $display("FAIL wrap_flags got %0b/%0d want 0/0", b4.overflow, b4.drop_count);
    end
  endtask

  task automatic test_ce_gate();
    bit ce_seq [4];
    ce_seq[0] = 1; ce_seq[1] = 0; ce_seq[2] = 0; ce_seq[3] = 1;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_in(ce_seq[i], 1, 0, 0);
      step();
    end
    vectors++;
    if (b.fifo_level !== 4'd2 || b.ts_data !== 16'd0) begin
      miscompares++; $display("FAIL ce_level got %0d/%0d want 2/0", b.fifo_level, b.ts_data);
    end
    set_in(0, 1, 1, 0);
    step();
    vectors++;
    if (b.ts_valid !== 1'b1 || b.ts_data !== 16'd1 || b.fifo_level !== 4'd1) begin
      miscompares++;
      $display("FAIL ce_drain1 got v %0b data %0d lvl %0d want 1/1/1", b.ts_valid, b.ts_data, b.fifo_level);
    end
    step();
    vectors++;
    if (b.ts_valid !== 1'b0 || b.ts_data !== 16'd1 || b.fifo_level !== 4'd0) begin
      miscompares++;
      $display("FAIL ce_drain2 got v %0b data %0d lvl %0d want 0/1/0", b.ts_valid, b.ts_data, b.fifo_level);
    end
  endtask

  task automatic test_clear_reset();
    do_reset();
    set_in(1, 1, 0, 0);
    repeat (9) step();
    set_in(1, 0, 1, 0);
    repeat (5) step();
    vectors++;
    if (b.fifo_level !== 4'd3 || b.overflow !== 1'b1) begin
      miscompares++; $display("FAIL clr_pre got %0d/%0b want 3/1", b.fifo_level, b.overflow);
    end
    set_in(1, 1, 1, 1);
    step();
    set_in(1, 0, 0, 0);
    vectors++;
    if (b.fifo_level !== 4'd0 || b.ts_valid !== 1'b0 || b.overflow !== 1'b0 ||
        b.drop_count !== 8'd0) begin
      miscompares++;
      $display("FAIL clear_post got lvl %0d v %0b ovf %0b drops %0d want all 0",
               b.fifo_level, b.ts_valid, b.overflow, b.drop_count);
    end
    set_in(1, 1, 0, 0);
    repeat (3) step();
    #3 rst_n = 1'b0;
    #1;
    vectors++;
    if (b.ts_valid !== 1'b0 || b.ts_data !== 16'd0 || b.fifo_level !== 4'd0 ||
        b.overflow !== 1'b0 || b.drop_count !== 8'd0 || b4.ts_data !== 4'd0) begin
      miscompares++;
      $display("FAIL async_reset got v %0b data %0d lvl %0d want all 0",
               b.ts_valid, b.ts_data, b.fifo_level);
    end
    set_in(0, 0, 0, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    set_in(1, 1, 0, 0);
    step();
    set_in(1, 0, 0, 0);
    vectors++;
    if (b.ts_valid !== 1'b1 || b.ts_data !== 16'd0 || b.ts_data !== m_head) begin
      miscompares++;
      $display("FAIL post_reset_stamp got v %0b data %0d want 1/0", b.ts_valid, b.ts_data);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    set_in(1, 1, 0, 0);
    repeat (D + 260) step();
    vectors++;
    if (b.drop_count !== 8'd255 || b.drop_count !== 8'(m_drops) || b.overflow !== 1'b1) begin
      miscompares++;
      $display("FAIL saturate got %0d/%0b want 255/1", b.drop_count, b.overflow);
    end
    vectors++;
    if (b.fifo_level !== 4'd8 || b.ts_data !== 16'd0) begin
      miscompares++;
      $display("FAIL sat_contents got lvl %0d data %0d want 8/0", b.fifo_level, b.ts_data);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      set_in($urandom_range(3, 0) != 0, $urandom_range(9, 0) < 4,
             $urandom_range(1, 0) == 1, $urandom_range(31, 0) == 0);
      step();
      vectors++;
      if (b.ts_valid !== (q.size() > 0) || b.fifo_level !== 4'(q.size())) begin
        miscompares++;
        $display("FAIL rnd_occ cyc %0d got v %0b lvl %0d want %0d entries",
                 i, b.ts_valid, b.fifo_level, q.size());
      end
      vectors++;
      if (b.ts_data !== m_head || b4.ts_data !== m_head[3:0]) begin
        miscompares++;
        $display("FAIL rnd_data cyc %0d got %0d/%0d want %0d", i, b.ts_data, b4.ts_data, m_head);
      end
      vectors++;
      if (b.overflow !== m_ovf || b.drop_count !== 8'(m_drops)) begin
        miscompares++;
        $display("FAIL rnd_status cyc %0d got %0b/%0d want %0b/%0d",
                 i, b.overflow, b.drop_count, m_ovf, m_drops);
      end
    end
  endtask

  initial begin
    set_in(0, 0, 0, 0);
    model_reset();
    test_reset();
    test_basic();
    test_overflow();
    test_wrap();
    test_ce_gate();
    test_clear_reset();
    test_saturate();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
